mem_responder: RTL and testbench

// - Memory-side responder for the execution unit's operand/result traffic: 8-bit x 16-entry data store.
// - Serves one request at a time: operand reads (A, B) and the ALU result write.
// - Request/response valid-ready handshake with programmable wait states, so EU sequencing is cycle-accurate.
// - Sits between the EU access sequencer and storage; replaces the direct combinational memory hookup.

---
 rtl/mem_responder_if.sv | 32 +++
 rtl/mem_responder.sv | 176 +++++++++++++++++
 tb/tb_mem_responder.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/mem_responder_if.sv
// Request/response bus between the EU access sequencer (master) and the
// memory responder (slave).
//   req_valid / req_ready : request handshake
//   req_we                : 1 = write, 0 = read
//   req_addr / req_wdata  : entry address and write data
//   rsp_valid / rsp_ready : response handshake
//   rsp_rdata             : read data, or echoed write data on a write ack
//   rsp_err               : address error flag
interface mem_responder_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/mem_responder.sv
// Memory-side responder for EU operand/result traffic. Serves one request at
// a time from a DEPTH x DATA_W register array, with WAIT_CYCLES programmable
// wait states between request accept and response.
// Ports:
//   clk  : single clock, rising edge
//   rst  : synchronous, active-high reset (clears FSM and whole array)
//   bus  : mem_responder_if.slave (request/response handshake)
// Optional feature: define MEM_BOUNDS_CHECK_EN to flag addresses >= DEPTH
// on rsp_err (rsp_rdata forced to 0). Without it rsp_err is tied 0.
//
// state  | meaning
// S_IDLE | ready for a request, req_ready=1
// S_WAIT | request latched, down-counting wait states
// S_RESP | response presented, held until rsp_ready
module mem_responder #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 4,
  parameter int DEPTH       = 16,
  parameter int WAIT_CYCLES = 1
) (
  input  logic           clk,
  input  logic           rst,
  mem_responder_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [3:0]      CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
  localparam logic [ADDR_W:0] DEPTH_L  = (ADDR_W + 1)'(DEPTH);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              lat_we_q, lat_we_d;
  logic [ADDR_W-1:0] lat_addr_q, lat_addr_d;
  logic [DATA_W-1:0] lat_wdata_q, lat_wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  logic              accept;
  logic              access;
  logic              acc_we;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  logic              in_range;

  assign accept = bus.req_valid && (state_q == S_IDLE);

  // With zero wait states the access happens on the accept edge itself, so
  // it must use the live request rather than the (not yet loaded) latches.
  assign access = (accept && (WAIT_CYCLES == 0)) ||
                  ((state_q == S_WAIT) && (cnt_q == 4'd0));

  always_comb begin
    acc_we    = lat_we_q;
    acc_addr  = lat_addr_q;
    acc_wdata = lat_wdata_q;
    if (state_q == S_IDLE) begin
      acc_we    = bus.req_we;
      acc_addr  = bus.req_addr;
      acc_wdata = bus.req_wdata;
    end
  end

  assign in_range = ({1'b0, acc_addr} < DEPTH_L);

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
      S_WAIT: if (cnt_q == 4'd0) state_d = S_RESP;
      S_RESP: if (bus.rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // output logic
  always_comb begin
    bus.req_ready = (state_q == S_IDLE);
    bus.rsp_valid = (state_q == S_RESP);
    bus.rsp_rdata = rdata_q;
  end

  // datapath next values
  always_comb begin
    cnt_d       = cnt_q;
    lat_we_d    = lat_we_q;
    lat_addr_d  = lat_addr_q;
    lat_wdata_d = lat_wdata_q;
    rdata_d     = rdata_q;
    mem_d       = mem_q;

    if (accept) begin
      lat_we_d    = bus.req_we;
      lat_addr_d  = bus.req_addr;
      lat_wdata_d = bus.req_wdata;
      cnt_d       = CNT_INIT;
    end else if ((state_q == S_WAIT) && (cnt_q != 4'd0)) begin
      cnt_d = cnt_q - 4'd1;
    end

    if (access) begin
      if (in_range) begin
        if (acc_we) begin
          mem_d[acc_addr] = acc_wdata;
          rdata_d         = acc_wdata;
        end else begin
          rdata_d = mem_q[acc_addr];
        end
      end else begin
`ifdef MEM_BOUNDS_CHECK_EN
        rdata_d = '0;
`else
        // silent drop: a write ack still echoes its data, a read returns 0
        rdata_d = acc_we ? acc_wdata : '0;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      lat_we_q    <= 1'b0;
      lat_addr_q  <= '0;
      lat_wdata_q <= '0;
      rdata_q     <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      cnt_q       <= cnt_d;
      lat_we_q    <= lat_we_d;
      lat_addr_q  <= lat_addr_d;
      lat_wdata_q <= lat_wdata_d;
      rdata_q     <= rdata_d;
      mem_q       <= mem_d;
    end
  end

`ifdef MEM_BOUNDS_CHECK_EN
  logic err_q, err_d;

  // the access result wins when accept and access share a cycle
  always_comb begin
    err_d = err_q;
    if (accept) err_d = 1'b0;
    if (access) err_d = !in_range;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign bus.rsp_err = err_q;
`else
  assign bus.rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;
  localparam int W = 2;
  localparam int D = 12;
`ifdef MEM_BOUNDS_CHECK_EN
  localparam bit BC = 1'b1;
`else
  localparam bit BC = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_responder_if #(.DATA_W(8), .ADDR_W(4)) bus ();

  mem_responder #(.DATA_W(8), .ADDR_W(4), .DEPTH(D), .WAIT_CYCLES(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model: one outstanding transaction, response due W+1 cycles
  // after the cycle it was accepted in, stays until rsp_ready is seen.
  logic [7:0] m_mem [16];
  bit         m_init = 1'b0;
  bit         m_out  = 1'b0;
  int         m_due  = 0;
  int         cyc    = 0;
  logic [7:0] m_rd   = 8'h00;
  logic       m_er   = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_init = 1'b1;
      m_out  = 1'b0;
      for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
    end else if (m_out) begin
      if (cyc >= m_due && bus.rsp_ready) m_out = 1'b0;
    end else if (bus.req_valid) begin
      m_out = 1'b1;
      m_due = cyc + W + 1;
      if (int'(bus.req_addr) >= D) begin
        m_er = BC;
        m_rd = (bus.req_we && !BC) ? bus.req_wdata : 8'h00;
      end else begin
        m_er = 1'b0;
        if (bus.req_we) begin
          m_mem[bus.req_addr] = bus.req_wdata;
          m_rd = bus.req_wdata;
        end else begin
          m_rd = m_mem[bus.req_addr];
        end
      end
    end
    cyc++;
  end

  always begin
    @(posedge clk);
    #1;
    if (m_init) begin
      chk("rsp_valid", {31'd0, bus.rsp_valid}, {31'd0, m_out && (cyc >= m_due)});
      chk("req_ready", {31'd0, bus.req_ready}, {31'd0, !m_out});
      if (m_out && cyc >= m_due) begin
        chk("rsp_rdata", {24'd0, bus.rsp_rdata}, {24'd0, m_rd});
        chk("rsp_err", {31'd0, bus.rsp_err}, {31'd0, m_er});
      end
    end
  end

  // all driver tasks start and end just after a falling edge
  task automatic req(input logic we, input logic [3:0] a, input logic [7:0] d,
                     input int hold, input bit keepv,
                     output logic [7:0] rd, output logic er, output int lat);
    int n;
    n = 0;
    while (!bus.req_ready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk("req_ready_timeout", 32'd0, 32'd1);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = a;
    bus.req_wdata = d;
    @(negedge clk);
    if (keepv) begin
      bus.req_we   = 1'b0;
      bus.req_addr = 4'd9;
    end else begin
      bus.req_valid = 1'b0;
    end
    n = 0;
    while (!bus.rsp_valid && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk("rsp_valid_timeout", 32'd0, 32'd1);
    lat = n;
    repeat (hold) @(negedge clk);
    bus.rsp_ready = 1'b1;
    rd = bus.rsp_rdata;
    er = bus.rsp_err;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b0;
  endtask

  logic [7:0] rd;
  logic       er;
  int         lat;

  initial begin
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = 4'd0;
    bus.req_wdata = 8'd0;
    bus.rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset_req_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("reset_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("reset_rsp_rdata", {24'd0, bus.rsp_rdata}, 32'd0);
    chk("reset_rsp_err",   {31'd0, bus.rsp_err},   32'd0);

    req(1'b0, 4'd3, 8'h00, 0, 1'b0, rd, er, lat);
    chk("first_read_data", {24'd0, rd}, 32'h00);
    chk("first_read_err", {31'd0, er}, 32'd0);
    chk("first_read_latency", lat, W);

    req(1'b1, 4'd7, 8'hA5, 0, 1'b0, rd, er, lat);
    chk("write_ack_a5", {24'd0, rd}, 32'hA5);
    req(1'b0, 4'd7, 8'h00, 0, 1'b0, rd, er, lat);
    chk("read_back_a5", {24'd0, rd}, 32'hA5);

    req(1'b1, 4'd1, 8'h12, 0, 1'b0, rd, er, lat);
    req(1'b1, 4'd2, 8'h34, 1, 1'b0, rd, er, lat);
    req(1'b0, 4'd1, 8'h00, 0, 1'b0, rd, er, lat);
    chk("eu_read1", {24'd0, rd}, 32'h12);
    req(1'b0, 4'd2, 8'h00, 2, 1'b0, rd, er, lat);
    chk("eu_read2", {24'd0, rd}, 32'h34);
    req(1'b1, 4'd3, 8'h46, 0, 1'b0, rd, er, lat);
    req(1'b0, 4'd3, 8'h00, 0, 1'b0, rd, er, lat);
    chk("eu_read3", {24'd0, rd}, 32'h46);

    req(1'b1, 4'd5, 8'h5C, 0, 1'b0, rd, er, lat);
    req(1'b0, 4'd5, 8'h00, 5, 1'b1, rd, er, lat);
    chk("backpressure_read", {24'd0, rd}, 32'h5C);

    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 4'd4;
    bus.req_wdata = 8'hFF;
    @(negedge clk);
    bus.req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midreset_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("midreset_req_ready", {31'd0, bus.req_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    req(1'b0, 4'd4, 8'h00, 0, 1'b0, rd, er, lat);
    chk("after_reset_read4", {24'd0, rd}, 32'h00);
    req(1'b0, 4'd7, 8'h00, 0, 1'b0, rd, er, lat);
    chk("after_reset_read7", {24'd0, rd}, 32'h00);

    req(1'b1, 4'd14, 8'h77, 0, 1'b0, rd, er, lat);
    chk("oor_write_err", {31'd0, er}, {31'd0, BC});
    chk("oor_write_ack", {24'd0, rd}, BC ? 32'h00 : 32'h77);
    req(1'b0, 4'd14, 8'h00, 0, 1'b0, rd, er, lat);
    chk("oor_read_data", {24'd0, rd}, 32'h00);
    chk("oor_read_err", {31'd0, er}, {31'd0, BC});
    req(1'b0, 4'd2, 8'h00, 0, 1'b0, rd, er, lat);
    chk("err_cleared", {31'd0, er}, 32'd0);

    for (int k = 0; k < 80; k++) begin
      req(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom),
          int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), rd, er, lat);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
